// File: rtl/lsu_mem_arbiter.sv
// Two-requester arbiter for the single data-memory port: grants one LSU-style
// requester, registers its request, runs one valid/ready transaction and routes
// done/rdata back. Define LSU_MEM_ARBITER_FIXED_PRIO_EN for fixed priority (m0 wins).
module lsu_mem_arbiter #(
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_ren,
  input  logic        m0_wen,
  input  logic [1:0]  m0_type,
  input  logic [31:0] m0_addr_base,
  input  logic [31:0] m0_addr_offset,
  input  logic [31:0] m0_wdata,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  input  logic        m1_ren,
  input  logic        m1_wen,
  input  logic [1:0]  m1_type,
  input  logic [31:0] m1_addr_base,
  input  logic [31:0] m1_addr_offset,
  input  logic [31:0] m1_wdata,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic        owner_r, owner_nxt_s;
  logic [31:0] addr_r, addr_nxt_s;
  logic [31:0] wdata_r, wdata_nxt_s;
  logic [3:0]  we_r, we_nxt_s;

  logic        req0_s, req1_s, grant_s;
  logic        sel_wr_s;
  logic [1:0]  sel_type_s;
  logic [31:0] sel_addr_s, sel_wdata_s;

`ifndef LSU_MEM_ARBITER_FIXED_PRIO_EN
  logic        prio_r, prio_nxt_s;
`endif

  // Byte-enable pattern: size mask shifted into the addressed lanes, upper lanes dropped.
  function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask << off;
  endfunction

  // Right-aligned store data replicated across all byte lanes.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] rep;
    case (size)
      2'b00:   rep = {4{data[7:0]}};
      2'b01:   rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

  assign req0_s = m0_ren | m0_wen;
  assign req1_s = m1_ren | m1_wen;

  // Grant decision and mux of the winning requester's fields.
  always_comb begin
    grant_s = 1'b0;
    if (req0_s && req1_s) begin
`ifdef LSU_MEM_ARBITER_FIXED_PRIO_EN
      grant_s = 1'b0;
`else
      grant_s = prio_r;
`endif
    end else if (req1_s) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end

    if (grant_s) begin
      sel_wr_s    = m1_wen;
      sel_type_s  = m1_type;
      sel_addr_s  = m1_addr_base + m1_addr_offset;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_wr_s    = m0_wen;
      sel_type_s  = m0_type;
      sel_addr_s  = m0_addr_base + m0_addr_offset;
      sel_wdata_s = m0_wdata;
    end
  end

  // Next-state logic: capture the granted request in IDLE, wait for mem_ready in BUSY.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    we_nxt_s    = we_r;
`ifndef LSU_MEM_ARBITER_FIXED_PRIO_EN
    prio_nxt_s  = prio_r;
`endif
    case (state_r)
      IDLE: begin
        if (req0_s || req1_s) begin
          state_nxt_s = BUSY;
          owner_nxt_s = grant_s;
          addr_nxt_s  = sel_addr_s;
          wdata_nxt_s = lane_data(sel_type_s, sel_wdata_s);
          we_nxt_s    = sel_wr_s ? lane_we(sel_type_s, sel_addr_s[1:0]) : 4'b0000;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_nxt_s = IDLE;
`ifndef LSU_MEM_ARBITER_FIXED_PRIO_EN
          prio_nxt_s  = ~owner_r;
`endif
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered memory-request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      we_r    <= 4'b0000;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      addr_r  <= addr_nxt_s;
      wdata_r <= wdata_nxt_s;
      we_r    <= we_nxt_s;
    end
  end

`ifndef LSU_MEM_ARBITER_FIXED_PRIO_EN
  // Round-robin pointer: after each completion it points at the non-owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= RESET_PRIO[0];
    end else begin
      prio_r <= prio_nxt_s;
    end
  end
`endif

  assign mem_valid = (state_r == BUSY);
  assign busy      = (state_r == BUSY);
  assign owner     = owner_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_we    = we_r;

  // Completion is combinational with mem_ready so done lands in the same cycle.
  assign m0_done  = mem_valid && mem_ready && (owner_r == 1'b0);
  assign m1_done  = mem_valid && mem_ready && (owner_r == 1'b1);
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed, table-driven bench for lsu_mem_arbiter plus hand-written sequences
// for arbitration, mid-flight request drop and reset during BUSY.
module tb_lsu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_ren, m0_wen, m1_ren, m1_wen;
  logic [1:0]  m0_type, m1_type;
  logic [31:0] m0_addr_base, m0_addr_offset, m0_wdata;
  logic [31:0] m1_addr_base, m1_addr_offset, m1_wdata;
  logic        m0_done, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic        busy, owner;

  int checks = 0;
  int failures = 0;

  lsu_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_type(m0_type),
    .m0_addr_base(m0_addr_base), .m0_addr_offset(m0_addr_offset), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_type(m1_type),
    .m1_addr_base(m1_addr_base), .m1_addr_offset(m1_addr_offset), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_rdata(m1_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        who;
    logic        ren;
    logic        wen;
    logic [1:0]  typ;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_addr;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic who, input logic ren, input logic wen, input logic [1:0] typ,
                         input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd);
    if (who) begin
      m1_ren = ren; m1_wen = wen; m1_type = typ;
      m1_addr_base = base; m1_addr_offset = off; m1_wdata = wd;
    end else begin
      m0_ren = ren; m0_wen = wen; m0_type = typ;
      m0_addr_base = base; m0_addr_offset = off; m0_wdata = wd;
    end
  endtask

  // One full transaction from a single requester; entered and left at a negedge in IDLE.
  task automatic run_txn(input vec_t v);
    set_req(v.who, v.ren, v.wen, v.typ, v.base, v.off, v.wdata);
    @(negedge clk);
    chk("valid_after_grant", {31'd0, mem_valid}, 32'd1);
    chk("busy_after_grant", {31'd0, busy}, 32'd1);
    chk("owner", {31'd0, owner}, {31'd0, v.who});
    chk("mem_addr", mem_addr, v.exp_addr);
    chk("mem_we", {28'd0, mem_we}, {28'd0, v.exp_we});
    if (v.wen) chk("mem_wdata", mem_wdata, v.exp_wdata);
    for (int i = 0; i < v.delay; i++) begin
      @(negedge clk);
      chk("no_done_while_waiting", {30'd0, m1_done, m0_done}, 32'd0);
      chk("valid_held", {31'd0, mem_valid}, 32'd1);
    end
    mem_ready = 1'b1;
    mem_rdata = v.rdata;
    #1;
    chk("owner_done", {31'd0, v.who ? m1_done : m0_done}, 32'd1);
    chk("other_done", {31'd0, v.who ? m0_done : m1_done}, 32'd0);
    chk("owner_rdata", v.who ? m1_rdata : m0_rdata, v.rdata);
    @(negedge clk);
    set_req(v.who, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
    mem_ready = 1'b0;
    chk("idle_after_done", {30'd0, busy, mem_valid}, 32'd0);
  endtask

  initial begin
    //        who   ren   wen   typ    base          off          wdata         rdata         dly addr          we       wdata
    vecs[0] = '{1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_0040, 32'h0000_0004, 32'h0,        32'hDEAD_BEEF, 2, 32'h0000_0044, 4'b0000, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0060, 32'h0000_0003, 32'h0000_00A5, 32'h1,        1, 32'h0000_0063, 4'b1000, 32'hA5A5_A5A5};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0062, 32'h0000_0000, 32'h0000_1234, 32'h2,        0, 32'h0000_0062, 4'b1100, 32'h1234_1234};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 2'b11, 32'hFFFF_FFFC, 32'h0000_0008, 32'hCAFE_F00D, 32'h3,        1, 32'h0000_0004, 4'b1111, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 32'h0000_0001, 32'h1234_567F, 32'h4,        0, 32'h0000_0001, 4'b0010, 32'h7F7F_7F7F};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_0001, 32'h0000_0002, 32'h5555_ABCD, 32'h5,        3, 32'h0000_0003, 4'b1000, 32'hABCD_ABCD};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 2'b10, 32'h0000_0100, 32'h0000_0000, 32'h1122_3344, 32'h6,        0, 32'h0000_0100, 4'b1111, 32'h1122_3344};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0020, 32'h0000_0011, 32'h0,        32'h0BAD_F00D, 0, 32'h0000_0031, 4'b0000, 32'h0};

    rst_n = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
    #12;
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_we", {28'd0, mem_we}, 32'd0);
    chk("rst_done", {30'd0, m1_done, m0_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters hold continuously: expect m0,m1,m0,m1 (or m0 always with fixed priority).
    set_req(1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_0010, 32'h0, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_0020, 32'h0, 32'h0);
    for (int t = 0; t < 4; t++) begin
      logic exp_own;
`ifdef LSU_MEM_ARBITER_FIXED_PRIO_EN
      exp_own = 1'b0;
`else
      exp_own = t[0];
`endif
      @(negedge clk);
      chk("arb_valid", {31'd0, mem_valid}, 32'd1);
      chk("arb_owner", {31'd0, owner}, {31'd0, exp_own});
      chk("arb_addr", mem_addr, exp_own ? 32'h0000_0020 : 32'h0000_0010);
      mem_ready = 1'b1;
      mem_rdata = 32'hA000_0000 + t;
      #1;
      chk("arb_done", {30'd0, m1_done, m0_done}, exp_own ? 32'd2 : 32'd1);
      @(negedge clk);
      mem_ready = 1'b0;
      chk("arb_idle_gap", {30'd0, busy, mem_valid}, 32'd0);
    end
    m0_ren = 1'b0;
    @(negedge clk);
    chk("arb_m1_after_m0_stops", {31'd0, owner}, 32'd1);
    m1_ren = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("arb_m1_done", {30'd0, m1_done, m0_done}, 32'd2);
    @(negedge clk);
    mem_ready = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Owner drops its request mid-flight; transaction must still complete unchanged.
    set_req(1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_0200, 32'h0, 32'h0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 32'hFFFF_0000, 32'h0000_0123, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("drop_valid_held", {31'd0, mem_valid}, 32'd1);
      chk("drop_addr_held", mem_addr, 32'h0000_0200);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h7777_8888;
    #1;
    chk("drop_done", {30'd0, m1_done, m0_done}, 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("drop_idle", {31'd0, mem_valid}, 32'd0);

    // Reset asserted while BUSY forces idle outputs immediately.
    set_req(1'b1, 1'b0, 1'b1, 2'b10, 32'h0000_0300, 32'h0, 32'h1111_2222);
    @(negedge clk);
    chk("prerst_busy", {31'd0, busy}, 32'd1);
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, mem_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {30'd0, m1_done, m0_done}, 32'd0);
    chk("midrst_owner", {31'd0, owner}, 32'd0);
    chk("midrst_we", {28'd0, mem_we}, 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_txn('{1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_0400, 32'h0000_0008, 32'h0, 32'h1357_9BDF, 1,
              32'h0000_0408, 4'b0000, 32'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
